// File: rtl/ac_motor_pkg.sv
// Shared types and constants for the three-phase motor sequencer.
// Holds the state encoding, the six-step phase table and the settle-time helper.
package ac_motor_pkg;

    localparam int unsigned PWM_W    = 8;
    localparam int unsigned STEP_W   = 16;
    localparam int unsigned DELAY_W  = 11;
    localparam int unsigned SETTLE_W = DELAY_W + 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        FLT   = 3'd4
    } state_t;

    // Phase pattern {C,B,A} per commutation step, index 0 in the low slot
    localparam logic [5:0][2:0] STEP_TABLE = {
        3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001
    };

    // Cycles needed for every switch unit's dead-time counter to settle
    function automatic logic [SETTLE_W-1:0] settle_count(input logic [DELAY_W-1:0] d);
        return {1'b0, d, 1'b0} + SETTLE_W'(2);
    endfunction

endpackage

// File: rtl/ac_motor_step_timer.sv
// Commutation step divider and free-running PWM counter, both held at zero by clear.
// step_wrap is combinational and marks the last cycle of a step.
module ac_motor_step_timer #(
    parameter int unsigned PWM_W  = ac_motor_pkg::PWM_W,
    parameter int unsigned STEP_W = ac_motor_pkg::STEP_W
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [STEP_W-1:0] step_period,
    output logic              step_wrap,
    output logic [PWM_W-1:0]  pwm_cnt
);
    import ac_motor_pkg::*;

    localparam logic [PWM_W-1:0] PWM_LAST = {{(PWM_W-1){1'b1}}, 1'b0};

    logic [STEP_W-1:0] step_cnt;
    logic [STEP_W-1:0] step_last;

    // A zero period behaves as a one-cycle step; >= recovers if the period shrinks
    assign step_last = (step_period == '0) ? '0 : step_period - STEP_W'(1);
    assign step_wrap = !clear && (step_cnt >= step_last);

    always_ff @(posedge clk) begin
        if (clear || step_wrap) begin
            step_cnt <= '0;
        end else begin
            step_cnt <= step_cnt + STEP_W'(1);
        end
        if (clear || pwm_cnt >= PWM_LAST) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
        end
    end

endmodule

// File: rtl/ac_motor_phase_sequencer.sv
// Six-step PWM phase sequencer with safe arm/drain/fault handling for the bridge switch units.
// Optional duty soft-start ramp is enabled by defining AC_MOTOR_SOFT_START_EN.
module ac_motor_phase_sequencer #(
    parameter int unsigned PWM_W   = ac_motor_pkg::PWM_W,
    parameter int unsigned STEP_W  = ac_motor_pkg::STEP_W,
    parameter int unsigned DELAY_W = ac_motor_pkg::DELAY_W
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               START,
    input  logic               STOP,
    input  logic               FAULT,
    input  logic               FAULT_CLR,
    input  logic               DIR,
    input  logic [STEP_W-1:0]  STEP_PERIOD,
    input  logic [PWM_W-1:0]   DUTY,
    input  logic [DELAY_W-1:0] DEAD_TIME,
    output logic [2:0]         S_IN,
    output logic               SW_ENABLE,
    output logic [DELAY_W-1:0] DELAY,
    output logic [2:0]         STATE,
    output logic [2:0]         STEP
);
    import ac_motor_pkg::*;

    localparam int unsigned      CNT_W    = DELAY_W + 2;
    localparam logic [PWM_W-1:0] PWM_LAST = {{(PWM_W-1){1'b1}}, 1'b0};

    state_t             state;
    logic [CNT_W-1:0]   settle;
    logic               clear;
    logic               step_wrap;
    logic [PWM_W-1:0]   pwm_cnt;
    logic [PWM_W-1:0]   pwm_ahead;
    logic [PWM_W-1:0]   duty_run;
    logic [PWM_W-1:0]   duty_entry;
    logic [2:0]         step_adv;
    logic [2:0]         step_run;
    logic [2:0]         s_in_run;
    logic [2:0]         s_in_entry;

    assign STATE = state;
    assign clear = RESET || (state != RUN);

    ac_motor_step_timer #(
        .PWM_W  (PWM_W),
        .STEP_W (STEP_W)
    ) u_timer (
        .clk         (CLK),
        .clear       (clear),
        .step_period (STEP_PERIOD),
        .step_wrap   (step_wrap),
        .pwm_cnt     (pwm_cnt)
    );

`ifdef AC_MOTOR_SOFT_START_EN
    logic [PWM_W-1:0] duty_eff;

    // Ramp up one count per step wrap, follow reductions at once, restart from 0 on every RUN entry
    always_ff @(posedge CLK) begin
        if (!RESET && !FAULT && !STOP && state == RUN) begin
            duty_eff <= duty_run;
        end else begin
            duty_eff <= '0;
        end
    end

    always_comb begin
        duty_entry = '0;
        duty_run   = duty_eff;
        if (DUTY < duty_eff) begin
            duty_run = DUTY;
        end else if (step_wrap && duty_eff < DUTY) begin
            duty_run = duty_eff + PWM_W'(1);
        end
    end
`else
    always_comb begin
        duty_entry = DUTY;
        duty_run   = DUTY;
    end
`endif

    // Outputs are registered from the values the counters take after this edge
    always_comb begin
        step_adv   = DIR ? ((STEP == 3'd0) ? 3'd5 : STEP - 3'd1)
                         : ((STEP == 3'd5) ? 3'd0 : STEP + 3'd1);
        step_run   = step_wrap ? step_adv : STEP;
        pwm_ahead  = (pwm_cnt >= PWM_LAST) ? '0 : pwm_cnt + PWM_W'(1);
        s_in_run   = STEP_TABLE[step_run] & {3{pwm_ahead < duty_run}};
        s_in_entry = STEP_TABLE[0] & {3{duty_entry != '0}};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            settle    <= '0;
            S_IN      <= '0;
            SW_ENABLE <= 1'b0;
            DELAY     <= '0;
            STEP      <= '0;
        end else if (FAULT) begin
            state     <= FLT;
            S_IN      <= '0;
            SW_ENABLE <= 1'b0;
            STEP      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        state     <= ARM;
                        DELAY     <= DEAD_TIME;
                        settle    <= settle_count(DEAD_TIME);
                        SW_ENABLE <= 1'b1;
                    end
                end
                ARM: begin
                    if (STOP) begin
                        state  <= DRAIN;
                        settle <= settle_count(DELAY);
                    end else if (settle <= CNT_W'(1)) begin
                        state <= RUN;
                        STEP  <= '0;
                        S_IN  <= s_in_entry;
                    end else begin
                        settle <= settle - CNT_W'(1);
                    end
                end
                RUN: begin
                    if (STOP) begin
                        state  <= DRAIN;
                        settle <= settle_count(DELAY);
                        S_IN   <= '0;
                        STEP   <= '0;
                    end else begin
                        STEP <= step_run;
                        S_IN <= s_in_run;
                    end
                end
                DRAIN: begin
                    if (settle <= CNT_W'(1)) begin
                        state     <= IDLE;
                        SW_ENABLE <= 1'b0;
                    end else begin
                        settle <= settle - CNT_W'(1);
                    end
                end
                FLT: begin
                    if (FAULT_CLR) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    S_IN      <= '0;
                    SW_ENABLE <= 1'b0;
                    STEP      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ac_motor_phase_sequencer.sv
// Scoreboard bench for ac_motor_phase_sequencer: a cycle reference model queues expected outputs,
// a monitor compares them each cycle, and directed sequences check the headline timing cases.
module tb_ac_motor_phase_sequencer;
    import ac_motor_pkg::*;

    logic        CLK;
    logic        RESET, START, STOP, FAULT, FAULT_CLR, DIR;
    logic [15:0] STEP_PERIOD;
    logic [7:0]  DUTY;
    logic [10:0] DEAD_TIME;
    logic [2:0]  S_IN;
    logic        SW_ENABLE;
    logic [10:0] DELAY;
    logic [2:0]  STATE;
    logic [2:0]  STEP;

    ac_motor_phase_sequencer dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .START       (START),
        .STOP        (STOP),
        .FAULT       (FAULT),
        .FAULT_CLR   (FAULT_CLR),
        .DIR         (DIR),
        .STEP_PERIOD (STEP_PERIOD),
        .DUTY        (DUTY),
        .DEAD_TIME   (DEAD_TIME),
        .S_IN        (S_IN),
        .SW_ENABLE   (SW_ENABLE),
        .DELAY       (DELAY),
        .STATE       (STATE),
        .STEP        (STEP)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        int st;
        int en;
        int s_in;
        int delay;
        int step;
        bit step_chk;
    } exp_t;

    exp_t   exp_q[$];
    int     n_checks = 0;
    int     n_fails  = 0;
    state_t m_st     = IDLE;
    int     tbl[6]   = '{1, 3, 2, 6, 4, 5};

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    // Reference model: mode plus cycle counters, run time t drives both step and PWM position
    initial begin : model
        int   remain, t, step, duty, delay, p;
        bit   wrap;
        exp_t e;
        remain = 0; t = 0; step = 0; duty = 0; delay = 0;
        forever begin
            @(posedge CLK);
            if (RESET) begin
                m_st = IDLE; delay = 0; step = 0; t = 0; duty = 0;
            end else if (FAULT) begin
                m_st = FLT;
            end else begin
                case (m_st)
                    IDLE: if (START) begin
                        m_st = ARM; delay = int'(DEAD_TIME); remain = 2 * delay + 2;
                    end
                    ARM: if (STOP) begin
                        m_st = DRAIN; remain = 2 * delay + 2;
                    end else begin
                        remain--;
                        if (remain == 0) begin
                            m_st = RUN; t = 0; step = 0;
`ifdef AC_MOTOR_SOFT_START_EN
                            duty = 0;
`else
                            duty = int'(DUTY);
`endif
                        end
                    end
                    RUN: if (STOP) begin
                        m_st = DRAIN; remain = 2 * delay + 2;
                    end else begin
                        p = (STEP_PERIOD == 0) ? 1 : int'(STEP_PERIOD);
                        wrap = ((t % p) == p - 1);
                        t++;
                        if (wrap) step = DIR ? (step + 5) % 6 : (step + 1) % 6;
`ifdef AC_MOTOR_SOFT_START_EN
                        if (int'(DUTY) < duty) duty = int'(DUTY);
                        else if (wrap && duty < int'(DUTY)) duty++;
`else
                        duty = int'(DUTY);
`endif
                    end
                    DRAIN: begin
                        remain--;
                        if (remain == 0) m_st = IDLE;
                    end
                    FLT: if (FAULT_CLR) m_st = IDLE;
                    default: m_st = IDLE;
                endcase
            end
            e.st       = int'(m_st);
            e.en       = (m_st == ARM || m_st == RUN || m_st == DRAIN) ? 1 : 0;
            e.s_in     = (m_st == RUN && (t % 255) < duty) ? tbl[step] : 0;
            e.delay    = delay;
            e.step     = step;
            e.step_chk = (m_st == RUN);
            exp_q.push_back(e);
        end
    end

    // Monitor: one combined comparison per clock, sampled on the falling edge
    initial begin : monitor
        exp_t e;
        bit   ok;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                ok = (int'(STATE) == e.st) && (int'(SW_ENABLE) == e.en) &&
                     (int'(S_IN) == e.s_in) && (int'(DELAY) == e.delay) &&
                     (!e.step_chk || int'(STEP) == e.step);
                n_checks++;
                if (!ok) begin
                    n_fails++;
                    $display("FAIL scoreboard at %0t: state/en/s_in/delay/step got %0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d",
                             $time, STATE, SW_ENABLE, S_IN, DELAY, STEP,
                             e.st, e.en, e.s_in, e.delay, e.step);
                end
            end
        end
    end

    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic count_state(input state_t s, output int n, output int sin_nz);
        n = 0; sin_nz = 0;
        while (int'(STATE) == int'(s) && n < 500) begin
            n++;
            if (S_IN != 3'b000) sin_nz++;
            cyc();
        end
    endtask

    task automatic wait_state(input string name, input state_t s, input int budget);
        int k;
        k = 0;
        while (int'(STATE) != int'(s) && k < budget) begin
            k++;
            cyc();
        end
        check(name, int'(STATE), int'(s));
    endtask

    initial begin : stim
        int n, nz, bad, on_cnt;
        int steps[3];
        RESET = 1'b1; START = 1'b0; STOP = 1'b0; FAULT = 1'b0; FAULT_CLR = 1'b0;
        DIR = 1'b0; STEP_PERIOD = 16'd1; DUTY = 8'd0; DEAD_TIME = 11'd0;
        repeat (3) cyc();
        RESET = 1'b0;
        check("reset_state", int'(STATE), int'(IDLE));
        check("reset_enable", int'(SW_ENABLE), 0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (STATE != 3'd0 || S_IN != 3'b000 || SW_ENABLE || DELAY != 11'd0 || STEP != 3'd0) bad++;
        end
        check("idle_hold", bad, 0);

        // Start and forward run at full duty
        DEAD_TIME = 11'd5; STEP_PERIOD = 16'd10; DUTY = 8'd255; DIR = 1'b0; START = 1'b1;
        cyc();
        START = 1'b0;
        check("arm_enable", int'(SW_ENABLE), 1);
        count_state(ARM, n, nz);
        check("arm_cycles", n, 12);
        check("arm_s_in", nz, 0);
        check("delay_latched", int'(DELAY), 5);
        check("run_entered", int'(STATE), int'(RUN));
`ifdef AC_MOTOR_SOFT_START_EN
        check("soft_first_s_in", int'(S_IN), 0);
        repeat (60) cyc();
`else
        for (int s = 0; s < 6; s++) begin
            bad = 0;
            for (int i = 0; i < 10; i++) begin
                if (int'(S_IN) != tbl[s]) bad++;
                cyc();
            end
            check($sformatf("fwd_step%0d", s), bad, 0);
        end
`endif

        // Orderly stop
        STOP = 1'b1;
        cyc();
        STOP = 1'b0;
        check("stop_s_in", int'(S_IN), 0);
        count_state(DRAIN, n, nz);
        check("drain_cycles", n, 12);
        check("drain_to_idle", int'(STATE), int'(IDLE));
        check("idle_enable", int'(SW_ENABLE), 0);

        // Reverse order, partial duty, zero dead time
        DIR = 1'b1; DUTY = 8'd64; STEP_PERIOD = 16'd20; DEAD_TIME = 11'd0; START = 1'b1;
        cyc();
        START = 1'b0;
        count_state(ARM, n, nz);
        check("arm_zero_dt", n, 2);
        on_cnt = 0;
        for (int i = 0; i < 255; i++) begin
            if (S_IN != 3'b000) on_cnt++;
            if (i % 20 == 0 && i < 60) steps[i / 20] = int'(STEP);
            if (i == 100) DEAD_TIME = 11'd77;
            cyc();
        end
        check("rev_step0", steps[0], 0);
        check("rev_step1", steps[1], 5);
        check("rev_step2", steps[2], 4);
`ifndef AC_MOTOR_SOFT_START_EN
        check("pwm_on_count", on_cnt, 64);
`endif
        check("delay_stable_in_run", int'(DELAY), 0);
        STOP = 1'b1;
        cyc();
        STOP = 1'b0;
        wait_state("rev_back_idle", IDLE, 100);

        // Fault wins over a coincident stop; clear only once fault drops
        DEAD_TIME = 11'd3; DUTY = 8'd255; DIR = 1'b0; STEP_PERIOD = 16'd7; START = 1'b1;
        cyc();
        START = 1'b0;
        wait_state("fault_run", RUN, 100);
        repeat (5) cyc();
        FAULT = 1'b1; STOP = 1'b1;
        cyc();
        STOP = 1'b0;
        check("fault_state", int'(STATE), int'(FLT));
        check("fault_enable", int'(SW_ENABLE), 0);
        check("fault_s_in", int'(S_IN), 0);
        FAULT_CLR = 1'b1;
        cyc();
        FAULT_CLR = 1'b0;
        check("clr_ignored", int'(STATE), int'(FLT));
        FAULT = 1'b0;
        repeat (2) cyc();
        check("flt_holds", int'(STATE), int'(FLT));
        FAULT_CLR = 1'b1;
        cyc();
        FAULT_CLR = 1'b0;
        check("flt_cleared", int'(STATE), int'(IDLE));

        // Randomized traffic, period only changed while idle
        for (int i = 0; i < 6000; i++) begin
            START     = ($urandom % 8) == 0;
            STOP      = ($urandom % 400) == 0;
            FAULT_CLR = ($urandom % 8) == 0;
            if (!FAULT && ($urandom % 900) == 0) FAULT = 1'b1;
            else if (FAULT && ($urandom % 10) == 0) FAULT = 1'b0;
            if (($urandom % 30) == 0) DIR = 1'($urandom);
            if (($urandom % 40) == 0) DUTY = 8'($urandom);
            DEAD_TIME = 11'($urandom_range(0, 12));
            if (m_st == IDLE) STEP_PERIOD = 16'($urandom_range(0, 12));
            RESET = ($urandom % 1500) == 0;
            cyc();
        end
        RESET = 1'b0; START = 1'b0; STOP = 1'b0; FAULT = 1'b0; FAULT_CLR = 1'b0;
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
